// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants, slot phase type and enable helper for the 7-segment scan driver
package seg7_pkg;

   localparam logic [6:0] SEG_OFF    = 7'h7F;
   localparam int         DIGITS_MIN = 2;
   localparam int         DIGITS_MAX = 8;

   typedef enum logic {
      PH_BLANK = 1'b0,
      PH_SHOW  = 1'b1
   } slot_phase_t;

   // Active-low one-hot enable for digit idx, sized for the largest display.
   function automatic logic [DIGITS_MAX-1:0] digit_en_n(input logic [2:0] idx);
      return ~(DIGITS_MAX'(1) << idx);
   endfunction

endpackage

// File: rtl/seg7_hex_rom.sv
// rtl/seg7_hex_rom.sv - registered hex-to-segment ROM, active-low segments a..g (bit 6 = a)
// No reset: the owner masks the output until the first address has been latched.
module seg7_hex_rom
   import seg7_pkg::*;
(
   input  logic       clk,
   input  logic [3:0] i_addr,
   output logic [6:0] o_data
);

   logic [6:0] r_data;

   always_ff @(posedge clk) begin
      case (i_addr)
         4'h0: r_data <= 7'b0000001;
         4'h1: r_data <= 7'b1001111;
         4'h2: r_data <= 7'b0010010;
         4'h3: r_data <= 7'b0000110;
         4'h4: r_data <= 7'b1001100;
         4'h5: r_data <= 7'b0100100;
         4'h6: r_data <= 7'b0100000;
         4'h7: r_data <= 7'b0001111;
         4'h8: r_data <= 7'b0000000;
         4'h9: r_data <= 7'b0000100;
         4'hA: r_data <= 7'b0001000;
         4'hB: r_data <= 7'b1100000;
         4'hC: r_data <= 7'b0110001;
         4'hD: r_data <= 7'b1000010;
         4'hE: r_data <= 7'b0110000;
         default: r_data <= 7'b0111000;
      endcase
   end

   assign o_data = r_data;

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed common-anode 7-segment driver with frame-aligned updates
// Define SEG7_LZ_BLANK_EN to suppress leading zeros.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 50000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   output logic                  ready,
   input  logic [4*DIGITS-1:0]   value_in,
   input  logic [DIGITS-1:0]     dp_in,
   output logic [6:0]            seg_n,
   output logic [DIGITS-1:0]     an_n,
   output logic                  dp_n,
   output logic                  frame_done
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

   logic [CW-1:0]          r_cnt;
   logic [IW-1:0]          r_idx;
   logic [4*DIGITS-1:0]    r_act_val;
   logic [DIGITS-1:0]      r_act_dp;
   logic [4*DIGITS-1:0]    r_pend_val;
   logic [DIGITS-1:0]      r_pend_dp;
   logic                   r_pend;
   logic                   r_seg_mask;

   logic                   w_slot_end;
   logic                   w_wrap;
   logic                   w_xfer;
   logic [3:0]             w_nibble;
   logic [6:0]             w_rom_data;
   logic [DIGITS-1:0]      w_en_n;
   logic [DIGITS-1:0]      w_show;
   slot_phase_t            w_phase;

   assign w_slot_end = (r_cnt == CNT_LAST);
   assign w_wrap     = w_slot_end && (r_idx == IDX_LAST);
   assign w_xfer     = load && !r_pend;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
         r_idx <= '0;
      end else if (w_slot_end) begin
         r_cnt <= '0;
         r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // A transfer landing on the frame boundary skips the pending stage entirely.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_act_val  <= '0;
         r_act_dp   <= '0;
         r_pend_val <= '0;
         r_pend_dp  <= '0;
         r_pend     <= 1'b0;
      end else if (w_wrap) begin
         if (w_xfer) begin
            r_act_val <= value_in;
            r_act_dp  <= dp_in;
         end else if (r_pend) begin
            r_act_val <= r_pend_val;
            r_act_dp  <= r_pend_dp;
            r_pend    <= 1'b0;
         end
      end else if (w_xfer) begin
         r_pend_val <= value_in;
         r_pend_dp  <= dp_in;
         r_pend     <= 1'b1;
      end
   end

   // The ROM holds stale contents until it has latched one address after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_seg_mask <= 1'b1;
      end else begin
         r_seg_mask <= 1'b0;
      end
   end

   assign w_nibble = r_act_val[4*r_idx +: 4];

   seg7_hex_rom u_rom (
      .clk    (clk),
      .i_addr (w_nibble),
      .o_data (w_rom_data)
   );

`ifdef SEG7_LZ_BLANK_EN
   logic w_seen;

   always_comb begin
      w_seen = 1'b0;
      w_show = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         if (r_act_val[4*i +: 4] != 4'h0) begin
            w_seen = 1'b1;
         end
         w_show[i] = w_seen || r_act_dp[i] || (i == 0);
      end
   end
`else
   assign w_show = '1;
`endif

   // The blank slot at cnt == 0 hides the ROM's one-cycle latency after idx moves.
   assign w_phase = (r_cnt == '0) ? PH_BLANK : PH_SHOW;
   assign w_en_n  = DIGITS'(digit_en_n(3'(r_idx)));

   assign an_n       = (w_phase == PH_SHOW && w_show[r_idx]) ? w_en_n : '1;
   assign dp_n       = (w_phase == PH_SHOW) ? ~r_act_dp[r_idx] : 1'b1;
   assign seg_n      = r_seg_mask ? SEG_OFF : w_rom_data;
   assign ready      = ~r_pend;
   assign frame_done = w_wrap;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver against a frame-level model
module tb_seg7_scan_driver;

   localparam int DIGITS   = 4;
   localparam int SCAN_DIV = 4;
   localparam int FRAME    = DIGITS * SCAN_DIV;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic [15:0] value_in = '0;
   logic [3:0]  dp_in = '0;
   logic        ready;
   logic [6:0]  seg_n;
   logic [3:0]  an_n;
   logic        dp_n;
   logic        frame_done;

   seg7_scan_driver #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .ready      (ready),
      .value_in   (value_in),
      .dp_in      (dp_in),
      .seg_n      (seg_n),
      .an_n       (an_n),
      .dp_n       (dp_n),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   // Model state: t counts clock edges since reset release.
   int          t;
   logic [15:0] m_act, m_pend_v;
   logic [3:0]  m_act_dp, m_pend_dp;
   bit          m_pend;
   logic [6:0]  m_seg;

   logic [6:0] seg_tbl [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
      end
   endtask

   function automatic logic [3:0] nib(input logic [15:0] v, input int d);
      return 4'((v >> (4 * d)) & 16'hF);
   endfunction

   function automatic bit shown(input int d);
`ifdef SEG7_LZ_BLANK_EN
      int hi = 0;
      for (int i = 0; i < DIGITS; i++)
         if (nib(m_act, i) != 4'h0) hi = i;
      return (d <= hi) || m_act_dp[d];
`else
      return (d >= 0);
`endif
   endfunction

   task automatic model_reset();
      t = 0; m_act = '0; m_pend_v = '0; m_act_dp = '0; m_pend_dp = '0;
      m_pend = 1'b0; m_seg = 7'h7F;
   endtask

   task automatic check_outputs();
      int cnt = t % SCAN_DIV;
      int idx = (t / SCAN_DIV) % DIGITS;
      logic [3:0] exp_an;
      logic       exp_dp;
      exp_an = (cnt != 0 && shown(idx)) ? ~(4'b0001 << idx) : 4'hF;
      exp_dp = (cnt == 0) ? 1'b1 : ~m_act_dp[idx];
      chk("seg_n", 32'(seg_n), 32'(m_seg));
      chk("an_n", 32'(an_n), 32'(exp_an));
      chk("dp_n", 32'(dp_n), 32'(exp_dp));
      chk("ready", 32'(ready), 32'(!m_pend));
      chk("frame_done", 32'(frame_done), 32'((t % FRAME) == FRAME - 1));
   endtask

   task automatic model_edge(input bit ld, input logic [15:0] v, input logic [3:0] d);
      int  idx = (t / SCAN_DIV) % DIGITS;
      bit  xfer = ld && !m_pend;
      m_seg = seg_tbl[nib(m_act, idx)];
      if ((t % FRAME) == FRAME - 1) begin
         if (xfer) begin
            m_act = v; m_act_dp = d;
         end else if (m_pend) begin
            m_act = m_pend_v; m_act_dp = m_pend_dp; m_pend = 1'b0;
         end
      end else if (xfer) begin
         m_pend_v = v; m_pend_dp = d; m_pend = 1'b1;
      end
      t++;
   endtask

   task automatic run_cycle(input bit ld, input logic [15:0] v, input logic [3:0] d);
      check_outputs();
      load = ld; value_in = v; dp_in = d;
      @(posedge clk);
      model_edge(ld, v, d);
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic idle_until(input int phase);
      while ((t % FRAME) != phase) run_cycle(1'b0, 16'h0, 4'h0);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_seg"}, 32'(seg_n), 32'h7F);
      chk({tag, "_an"}, 32'(an_n), 32'hF);
      chk({tag, "_dp"}, 32'(dp_n), 32'h1);
      chk({tag, "_ready"}, 32'(ready), 32'h1);
      chk({tag, "_fd"}, 32'(frame_done), 32'h0);
   endtask

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_values("rst_init");
      rst = 1'b0;

      // Scan of 0x1234 with a decimal point on digit 1
      run_cycle(1'b1, 16'h1234, 4'b0010);
      repeat (FRAME) run_cycle(1'b0, 16'h0, 4'h0);
      idle_until(1);
      chk("scan_d0_an", 32'(an_n), 32'hE);
      chk("scan_d0_seg", 32'(seg_n), 32'h4C);
      idle_until(5);
      chk("scan_d1_seg", 32'(seg_n), 32'h06);
      chk("scan_d1_dp", 32'(dp_n), 32'h0);

      // Back-to-back loads: the second must be dropped
      idle_until(3);
      run_cycle(1'b1, 16'hAAAA, 4'h0);
      chk("hs_ready_low", 32'(ready), 32'h0);
      run_cycle(1'b1, 16'h5555, 4'h0);
      idle_until(1);
      chk("hs_d0_seg", 32'(seg_n), 32'h08);
      chk("hs_ready_back", 32'(ready), 32'h1);
      idle_until(13);
      chk("hs_d3_seg", 32'(seg_n), 32'h08);

      // Load in the wrap cycle goes straight to the display
      idle_until(FRAME - 1);
      run_cycle(1'b1, 16'hFFFF, 4'h0);
      chk("bnd_ready", 32'(ready), 32'h1);
      run_cycle(1'b0, 16'h0, 4'h0);
      chk("bnd_d0_seg", 32'(seg_n), 32'h38);
      chk("bnd_d0_an", 32'(an_n), 32'hE);

      // Leading zeros
      run_cycle(1'b1, 16'h0070, 4'h0);
      repeat (FRAME) run_cycle(1'b0, 16'h0, 4'h0);
      idle_until(5);
      chk("lz_d1_seg", 32'(seg_n), 32'h0F);
      idle_until(9);
`ifdef SEG7_LZ_BLANK_EN
      chk("lz_d2_an", 32'(an_n), 32'hF);
`else
      chk("lz_d2_an", 32'(an_n), 32'hB);
      chk("lz_d2_seg", 32'(seg_n), 32'h01);
`endif
      run_cycle(1'b1, 16'h0000, 4'h0);
      repeat (2 * FRAME) run_cycle(1'b0, 16'h0, 4'h0);

      // Mid-slot reset discards a pending update
      idle_until(3);
      run_cycle(1'b1, 16'hBEEF, 4'hF);
      run_cycle(1'b0, 16'h0, 4'h0);
      rst = 1'b1;
      #1;
      check_reset_values("rst_mid");
      @(negedge clk);
      check_reset_values("rst_hold");
      rst = 1'b0;
      model_reset();
      run_cycle(1'b0, 16'h0, 4'h0);
      chk("rst_rel_an", 32'(an_n), 32'hE);
      repeat (FRAME + 2) run_cycle(1'b0, 16'h0, 4'h0);

      // Randomized traffic
      for (int k = 0; k < 800; k++) begin
         run_cycle(($urandom_range(0, 3) == 0), 16'($urandom), 4'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
